// File: rtl/weight_load_ctrl_if.sv
// rtl/weight_load_ctrl_if.sv - weight_load_ctrl request, weight-store and downstream handshake bundle
interface weight_load_ctrl_if;
    logic       start;
    logic [3:0] cs_in;
    logic       ws_valid;
    logic       w_ready;
    logic       load;
    logic [3:0] cs;
    logic [2:0] phase;
    logic       w_valid;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, cs_in, ws_valid, w_ready,
        input  load, cs, phase, w_valid, busy, done, err
    );

    modport slave (
        input  start, cs_in, ws_valid, w_ready,
        output load, cs, phase, w_valid, busy, done, err
    );
endinterface

// File: rtl/weight_load_ctrl.sv
// rtl/weight_load_ctrl.sv - sequences per-phase weight-store loads for one layer
module weight_load_ctrl #(
    parameter int NUM_PHASE = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    weight_load_ctrl_if.slave bus
);
    // Layer codes shared with the layer-state logic; anything above AFFINE is illegal.
    localparam logic [3:0] LAYER0 = 4'd0;
    localparam logic [3:0] LAYER1 = 4'd1;
    localparam logic [3:0] LAYER2 = 4'd2;
    localparam logic [3:0] LAYER3 = 4'd3;
    localparam logic [3:0] AFFINE = 4'd4;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [2:0]    LAST_PHASE = 3'(NUM_PHASE - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_QUAL   = CW'(2);

    typedef enum logic [2:0] {IDLE, LOAD, HOLD, GAP, FIN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cs_legal;

    assign cs_legal = (bus.cs_in == LAYER0) || (bus.cs_in == LAYER1) ||
                      (bus.cs_in == LAYER2) || (bus.cs_in == LAYER3) ||
                      (bus.cs_in == AFFINE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bus.load    <= 1'b0;
            bus.cs      <= 4'd0;
            bus.phase   <= 3'd0;
            bus.w_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (cs_legal) begin
                            bus.cs    <= bus.cs_in;
                            bus.phase <= 3'd0;
                            bus.err   <= 1'b0;
                            bus.load  <= 1'b1;
                            bus.busy  <= 1'b1;
                            cnt       <= '0;
                            state     <= LOAD;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // The store's valid is stale for its first two cycles after load rises.
                    if (cnt >= CNT_QUAL && bus.ws_valid) begin
                        bus.w_valid <= 1'b1;
                        state       <= HOLD;
                    end else if (cnt == CNT_LAST) begin
                        bus.err  <= 1'b1;
                        bus.load <= 1'b0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.w_ready) begin
                        bus.load    <= 1'b0;
                        bus.w_valid <= 1'b0;
                        if (bus.phase == LAST_PHASE) begin
                            bus.done <= 1'b1;
                            state    <= FIN;
                        end else begin
                            bus.phase <= bus.phase + 3'd1;
                            state     <= GAP;
                        end
                    end
                end
                GAP: begin
                    bus.load <= 1'b1;
                    cnt      <= '0;
                    state    <= LOAD;
                end
                FIN: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb/tb_weight_load_ctrl.sv - randomized directed bench for weight_load_ctrl with timeline reference model
module tb_weight_load_ctrl;
    localparam int NP = 8;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    weight_load_ctrl_if bus ();
    weight_load_ctrl #(.NUM_PHASE(NP), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic       start;
        logic [3:0] cs_in;
        logic       ws_valid;
        logic       w_ready;
        logic       load;
        logic       w_valid;
        logic       busy;
        logic       done;
        logic       err;
        logic [2:0] phase;
        logic [3:0] cs;
    } slot_t;

    slot_t      q[$];
    int         hold_at[NP];
    int         lat[NP];
    int         rdy[NP];
    int         stale[NP];
    logic       m_err;
    logic [2:0] m_phase;
    logic [3:0] m_cs;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push(logic st, logic [3:0] ci, logic ws, logic wr,
                                 logic ld, logic wv, logic bz, logic dn);
        slot_t s;
        s.start = st; s.cs_in = ci; s.ws_valid = ws; s.w_ready = wr;
        s.load = ld; s.w_valid = wv; s.busy = bz; s.done = dn;
        s.err = m_err; s.phase = m_phase; s.cs = m_cs;
        q.push_back(s);
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rcs();
        return 4'($urandom_range(0, 15));
    endfunction

    // Timeline of one layer: each phase is a LOAD window (at least 3 cycles, ended by the first
    // qualified store valid or by the timeout), a HOLD window until w_ready, then GAP or FIN.
    function automatic void build_layer(logic [3:0] code);
        int n_load;
        push(1'b1, code, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0);
        m_err = 1'b0; m_phase = 3'd0; m_cs = code;
        for (int p = 0; p < NP; p++) hold_at[p] = -1;
        for (int p = 0; p < NP; p++) begin
            n_load = (lat[p] >= TO) ? TO : ((lat[p] < 2) ? 2 : lat[p]) + 1;
            for (int i = 0; i < n_load; i++)
                push(rb(), rcs(), (i < stale[p]) || (i >= lat[p]), rb(), 1'b1, 1'b0, 1'b1, 1'b0);
            if (lat[p] >= TO) begin
                m_err = 1'b1;
                push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            hold_at[p] = q.size();
            for (int j = 0; j <= rdy[p]; j++)
                push(rb(), rcs(), rb(), (j == rdy[p]), 1'b1, 1'b1, 1'b1, 1'b0);
            if (p == NP - 1) begin
                push(rb(), rcs(), rb(), rb(), 1'b0, 1'b0, 1'b1, 1'b1);
                push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            m_phase = 3'(p + 1);
            push(rb(), rcs(), 1'b1, rb(), 1'b0, 1'b0, 1'b1, 1'b0);
        end
    endfunction

    task automatic check_outputs(string tag, slot_t s);
        chk({tag, ".load"},    8'(bus.load),    8'(s.load));
        chk({tag, ".w_valid"}, 8'(bus.w_valid), 8'(s.w_valid));
        chk({tag, ".busy"},    8'(bus.busy),    8'(s.busy));
        chk({tag, ".done"},    8'(bus.done),    8'(s.done));
        chk({tag, ".err"},     8'(bus.err),     8'(s.err));
        chk({tag, ".phase"},   8'(bus.phase),   8'(s.phase));
        chk({tag, ".cs"},      8'(bus.cs),      8'(s.cs));
    endtask

    task automatic play(string tag, int upto);
        for (int t = 0; t < upto && t < q.size(); t++) begin
            check_outputs($sformatf("%s[%0d]", tag, t), q[t]);
            bus.start    = q[t].start;
            bus.cs_in    = q[t].cs_in;
            bus.ws_valid = q[t].ws_valid;
            bus.w_ready  = q[t].w_ready;
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    task automatic set_phases(int l, int r, int s);
        for (int p = 0; p < NP; p++) begin
            lat[p] = l; rdy[p] = r; stale[p] = s;
        end
    endtask

    task automatic randomize_phases();
        for (int p = 0; p < NP; p++) begin
            lat[p]   = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, 9);
            rdy[p]   = $urandom_range(0, 4);
            stale[p] = $urandom_range(0, 2);
        end
    endtask

    task automatic reset_model();
        m_err = 1'b0; m_phase = 3'd0; m_cs = 4'd0;
    endtask

    initial begin
        slot_t z;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.cs_in = 4'd0; bus.ws_valid = 1'b0; bus.w_ready = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        z = q[0];
        q.delete();
        check_outputs("reset", z);
        rst_n = 1'b1;

        // Nominal layer: store answers 6 cycles after load, consumer one cycle after w_valid.
        set_phases(6, 1, 0);
        build_layer(4'd1);
        play("nominal", q.size());

        // Store valid left high from the previous phase must not short-cut LOAD.
        set_phases(0, 0, 2);
        lat[3] = 1; lat[5] = 3;
        build_layer(4'd2);
        play("stale", q.size());

        // Illegal layer code: error only, no sequencing.
        push(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_err = 1'b1;
        push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        play("illegal", q.size());

        // Store never answers in phase 2.
        set_phases(3, 0, 1);
        lat[2] = 100;
        build_layer(4'd4);
        play("timeout", q.size());

        // Consumer stalls 20 cycles in phase 3.
        set_phases(2, 0, 0);
        rdy[3] = 20;
        build_layer(4'd0);
        play("stall", q.size());

        // Reset while holding phase 5.
        set_phases(4, 1, 0);
        rdy[5] = 4;
        build_layer(4'd3);
        play("prereset", hold_at[5] + 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        reset_model();
        for (int i = 0; i < 4; i++)
            push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play("midreset", q.size());
        set_phases(2, 0, 0);
        build_layer(4'd1);
        play("restart", q.size());

        // Random layers interleaved with random illegal requests.
        for (int k = 0; k < 6; k++) begin
            randomize_phases();
            build_layer(4'($urandom_range(0, 4)));
            play($sformatf("rand%0d", k), q.size());
            if (rb()) begin
                push(1'b1, 4'($urandom_range(5, 15)), rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0);
                m_err = 1'b1;
                push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                play($sformatf("randbad%0d", k), q.size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/weight_load_ctrl.md
WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_PHASE, default 8: phases sequenced per layer (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 15: max cycles from load assertion to ws_valid before error.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to sequence one layer's weights.
REQ-006 SHALL have port cs_in  input  4  layer code (`LAYER0..`LAYER3, `AFFINE from state_layer_data.v), sampled with start.
REQ-007 SHALL have port ws_valid  input  1  weight-store valid.
REQ-008 SHALL have port w_ready  input  1  downstream compute has consumed the current 36-weight word.
REQ-009 SHALL have port load  output  1  weight-store load enable.
REQ-010 SHALL have port cs  output  4  latched layer code to weight store.
REQ-011 SHALL have port phase  output  3  current phase to weight store.
REQ-012 SHALL have port w_valid  output  1  weight word is valid for downstream.
REQ-013 SHALL have port busy  output  1  sequence in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last phase is accepted.
REQ-015 SHALL have port err  output  1  sticky error flag.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, HOLD, GAP, FIN.
REQ-017 IDLE: on start with legal cs_in, SHALL latch cs<=cs_in, phase<=0, clear err, go LOAD; with illegal cs_in SHALL set err and stay IDLE.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 LOAD: load=1; a wait counter SHALL reset to 0 on entry and increment each cycle.
REQ-020 In LOAD, ws_valid SHALL be ignored while counter<2 (store's valid is stale from the previous phase until its init cycle clears it).
REQ-021 In LOAD with counter>=2 and ws_valid=1, SHALL go HOLD next cycle.
REQ-022 In LOAD, if counter reaches TIMEOUT without qualified ws_valid, SHALL set err, drop load, go IDLE.
REQ-023 HOLD: load=1, w_valid=1; SHALL remain until w_ready=1.
REQ-024 HOLD with w_ready=1: if phase==NUM_PHASE-1 go FIN, else phase<=phase+1 and go GAP.
REQ-025 GAP: load=0, w_valid=0 for exactly one cycle (re-arms store init), then LOAD.
REQ-026 FIN: load=0, done=1 for exactly one cycle, then IDLE.
REQ-027 busy SHALL be 1 in LOAD, HOLD, GAP, FIN; 0 in IDLE.
REQ-028 w_valid SHALL be 1 only in HOLD; load SHALL be 1 only in LOAD and HOLD.
REQ-029 phase SHALL never exceed NUM_PHASE-1 and SHALL hold its value in FIN/IDLE until next start.
REQ-030 cs SHALL remain stable from start acceptance through FIN.
REQ-031 w_ready outside HOLD SHALL have no effect.
REQ-032 err SHALL stay set until the next accepted legal start or reset.

Reset
REQ-033 On rst_n=0 at a clock edge, SHALL enter IDLE with load=0, w_valid=0, busy=0, done=0, err=0, phase=0, cs=0, counter=0.
REQ-034 Reset mid-sequence SHALL abort immediately; no done pulse SHALL be produced.

Verification
REQ-035 start, cs_in=`LAYER1, store model asserts valid 6 cycles after load, w_ready one cycle after w_valid -> phases 0..7 in order, 8 HOLD periods, one GAP cycle between each, single done pulse, busy falls with done.
REQ-036 Stale ws_valid=1 held high at LOAD entry -> no HOLD before LOAD counter=2.
REQ-037 ws_valid never asserted -> err=1, load=0, IDLE after TIMEOUT=15 cycles in LOAD.
REQ-038 start with cs_in=4'hF -> err=1, busy stays 0, load stays 0.
REQ-039 w_ready held low for 20 cycles in phase 3 -> w_valid and load stay 1, phase stays 3; w_ready=1 -> GAP then phase 4.
REQ-040 rst_n=0 during phase 5 HOLD -> next cycle all outputs at reset values, no done; new start restarts at phase 0.
